// File: rtl/sccb_init_sequencer.sv
// Walks a {reg_addr, reg_data} ROM table and issues one SCCB write per entry.
// It also generates the SCCB bit clock and the mid-low data pulse for the controller.
module sccb_init_sequencer #(
  parameter int unsigned CLK_DIV   = 256,
  parameter logic [7:0]  DEV_ID    = 8'h42,
  parameter int unsigned ROM_AW    = 8,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [23:0] DELAY_CYC = 24'd250000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              sccb_clk_o,
  output logic              data_pulse_o,
  output logic              start_o,
  output logic              rw_o,
  output logic [7:0]        addr_o,
  output logic [15:0]       data_o,
  input  logic              done_i,
  input  logic              ack_error_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ROM_AW-1:0] err_index_o
);

  localparam int unsigned CW        = $clog2(CLK_DIV);
  localparam int unsigned IW        = ROM_AW + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] PULSE_AT = CW'(3 * CLK_DIV / 4);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
  localparam logic [23:0] DLY_LAST  = DELAY_CYC - 24'd1;
  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [15:0] DLY_MARK  = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE, RELEASE, DELAY, DONE, ERROR
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [IW-1:0]  idx;
  logic [7:0]     retry;
  logic [23:0]    dly;
  logic           ack_err;

  // Bit-clock outputs are registered from the next count so they line up with cnt.
  assign cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt          <= '0;
      sccb_clk_o   <= 1'b1;
      data_pulse_o <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      sccb_clk_o   <= (cnt_nxt < HALF);
      data_pulse_o <= (cnt_nxt == PULSE_AT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (go_i) state_nxt = FETCH;
      FETCH:             state_nxt = DECODE;
      DECODE: begin
        // The extra index bit flags a walk past the last table slot.
        if (idx[ROM_AW] || rom_data_i == END_MARK) state_nxt = DONE;
        else if (rom_data_i == DLY_MARK)           state_nxt = DELAY;
        else                                       state_nxt = ISSUE;
      end
      ISSUE:   if (done_i) state_nxt = RELEASE;
      RELEASE: begin
        if (!done_i) begin
          if (!ack_err)               state_nxt = FETCH;
          else if (retry < RETRY_MAX) state_nxt = ISSUE;
          else                        state_nxt = ERROR;
        end
      end
      DELAY:   if (dly == DLY_LAST) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx         <= '0;
      retry       <= '0;
      dly         <= '0;
      ack_err     <= 1'b0;
      data_o      <= '0;
      addr_o      <= '0;
      err_index_o <= '0;
    end else begin
      addr_o <= DEV_ID;
      case (state)
        IDLE, DONE, ERROR: begin
          if (go_i) begin
            idx   <= '0;
            retry <= '0;
          end
        end
        DECODE: begin
          dly <= '0;
          if (rom_data_i != END_MARK && rom_data_i != DLY_MARK) data_o <= rom_data_i;
        end
        ISSUE: if (done_i) ack_err <= ack_error_i;
        RELEASE: begin
          if (!done_i) begin
            if (!ack_err) begin
              retry <= '0;
              idx   <= idx + IW'(1);
            end else if (retry < RETRY_MAX) begin
              retry <= retry + 8'd1;
            end else begin
              err_index_o <= idx[ROM_AW-1:0];
            end
          end
        end
        DELAY: begin
          dly <= dly + 24'd1;
          if (dly == DLY_LAST) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rom_addr_o = idx[ROM_AW-1:0];
  assign start_o    = (state == ISSUE);
  assign rw_o       = 1'b1;
  assign busy_o     = !(state == IDLE || state == DONE || state == ERROR);
  assign done_o     = (state == DONE);
  assign error_o    = (state == ERROR);

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: synchronous ROM, SCCB controller model with
// scripted NACKs, and a table-walking reference model of the expected writes.
module tb_sccb_init_sequencer;

  localparam int unsigned AW   = 4;
  localparam int unsigned NE   = 16;
  localparam int unsigned MAXR = 3;
  localparam logic [23:0] DLY  = 24'd100;
  localparam logic [7:0]  DEV  = 8'h42;

  logic          clk = 1'b0, rst_n = 1'b0, go = 1'b0;
  logic [AW-1:0] rom_addr, err_index;
  logic [15:0]   rom_q, data;
  logic          sccb_clk, data_pulse, start, rw, busy, done, error;
  logic [7:0]    addr;
  logic          done_i = 1'b0, ack_err = 1'b0;

  always #5 clk = ~clk;

  sccb_init_sequencer #(
    .CLK_DIV(8), .DEV_ID(DEV), .ROM_AW(AW), .MAX_RETRY(MAXR), .DELAY_CYC(DLY)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .go_i(go), .rom_addr_o(rom_addr), .rom_data_i(rom_q),
    .sccb_clk_o(sccb_clk), .data_pulse_o(data_pulse), .start_o(start), .rw_o(rw),
    .addr_o(addr), .data_o(data), .done_i(done_i), .ack_error_i(ack_err),
    .busy_o(busy), .done_o(done), .error_o(error), .err_index_o(err_index)
  );

  logic [15:0] tbl [NE];
  bit          nack_plan [NE][MAXR+1];

  always @(posedge clk) rom_q <= tbl[rom_addr];

  // Controller model: accept start, answer after a random latency, drop done on a data pulse.
  logic c_busy, c_nack;
  int   c_cnt;
  int   c_att [NE];
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_i <= 1'b0; ack_err <= 1'b0; c_busy <= 1'b0; c_cnt <= 0; c_nack <= 1'b0;
    end else begin
      if (go && !busy) for (int i = 0; i < NE; i++) c_att[i] <= 0;
      if (!c_busy && !done_i && start) begin
        c_busy <= 1'b1;
        c_cnt  <= int'($urandom_range(1, 12));
        c_nack <= nack_plan[rom_addr][(c_att[rom_addr] > MAXR) ? MAXR : c_att[rom_addr]];
        c_att[rom_addr] <= c_att[rom_addr] + 1;
      end else if (c_busy) begin
        if (c_cnt <= 1) begin
          c_busy <= 1'b0; done_i <= 1'b1; ack_err <= c_nack;
        end else c_cnt <= c_cnt - 1;
      end else if (done_i && !start && data_pulse) begin
        done_i <= 1'b0; ack_err <= 1'b0;
      end
    end
  end

  // Observer: records each start rise, the gap since the last done fall, and protocol slips.
  logic [15:0] obs_q [$];
  int          gap_q [$];
  int          cyc = 0, last_fall = 0, max_addr = 0, unstable = 0, viol = 0;
  bit          had_fall = 0;
  logic        start_q = 1'b0, done_q = 1'b0;
  logic [15:0] data_q = '0;
  logic [7:0]  addr_q = '0;
  always @(negedge clk) begin
    cyc++;
    if (go && !busy) begin
      obs_q.delete(); gap_q.delete();
      had_fall = 0; max_addr = 0; unstable = 0; viol = 0;
    end else begin
      if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (done_q && !done_i) begin last_fall = cyc; had_fall = 1; end
      if (start && !start_q) begin
        obs_q.push_back(data);
        gap_q.push_back(had_fall ? cyc - last_fall : -1);
        if (done_i || addr[7:1] != DEV[7:1] || !rw) viol++;
      end
      if (start && start_q && (data != data_q || addr != addr_q)) unstable++;
    end
    start_q = start; done_q = done_i; data_q = data; addr_q = addr;
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the table by the marker/retry rules.
  logic [15:0] exp_q [$];
  bit          exp_dl [$];
  bit          exp_done, exp_err;
  int          exp_eidx, exp_max;
  task automatic model();
    int idx = 0;
    bit pend = 0, ok;
    exp_q.delete(); exp_dl.delete();
    exp_done = 0; exp_err = 0; exp_eidx = 0; exp_max = 0;
    forever begin
      if (idx >= NE) begin exp_done = 1; exp_max = NE - 1; break; end
      if (tbl[idx] == 16'hFFFF) begin exp_done = 1; exp_max = idx; break; end
      if (tbl[idx] == 16'hFFF0) begin pend = 1; idx++; continue; end
      ok = 0;
      for (int a = 0; a <= MAXR; a++) begin
        exp_q.push_back(tbl[idx]);
        exp_dl.push_back(pend && a == 0);
        if (!nack_plan[idx][a]) begin ok = 1; break; end
      end
      if (!ok) begin exp_err = 1; exp_eidx = idx; exp_max = idx; break; end
      pend = 0; idx++;
    end
  endtask

  task automatic load(input logic [15:0] t [$]);
    for (int i = 0; i < NE; i++) begin
      tbl[i] = (i < t.size()) ? t[i] : 16'hFFFF;
      for (int a = 0; a <= MAXR; a++) nack_plan[i][a] = 0;
    end
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic run(input string tag, input bit go_twice);
    int n;
    model();
    pulse_go();
    if (go_twice && exp_q.size() > 0) begin
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
    end
    n = 0;
    while (!(done || error) && n < 20000) begin @(posedge clk); #1; n++; end
    check({tag, " timeout"}, (n >= 20000), 0);
    @(negedge clk);
    check({tag, " done_o"}, done, exp_done);
    check({tag, " error_o"}, error, exp_err);
    check({tag, " busy_o"}, busy, 0);
    if (exp_err) check({tag, " err_index_o"}, err_index, exp_eidx);
    check({tag, " starts"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s data_o[%0d]", tag, i), obs_q[i], exp_q[i]);
      if (exp_dl[i] && gap_q[i] >= 0)
        check($sformatf("%s delay gap[%0d]>=%0d (gap %0d)", tag, i, DLY, gap_q[i]),
              (gap_q[i] >= int'(DLY)), 1);
    end
    check({tag, " max rom_addr"}, max_addr, exp_max);
    check({tag, " data/addr stability"}, unstable, 0);
    check({tag, " start protocol"}, viol, 0);
  endtask

  initial begin
    logic [15:0] t [$];
    logic [15:0] v;
    int n, len;
    for (int i = 0; i < NE; i++) tbl[i] = 16'hFFFF;

    repeat (3) @(negedge clk);
    check("reset sccb_clk_o", sccb_clk, 1);
    check("reset rw_o", rw, 1);
    check("reset data_pulse_o", data_pulse, 0);
    check("reset start_o", start, 0);
    check("reset busy_o", busy, 0);
    check("reset done_o", done, 0);
    check("reset error_o", error, 0);
    check("reset addr_o", addr, 0);
    check("reset data_o", data, 0);
    check("reset rom_addr_o", rom_addr, 0);
    rst_n = 1'b1;

    // Bit-clock shape: falling edge is cnt 4, pulse two cycles later at cnt 6.
    n = 0;
    while (!sccb_clk && n < 20) begin @(negedge clk); n++; end
    while (sccb_clk && n < 20) begin @(negedge clk); n++; end
    check("sccb_clk fall found", (n < 20), 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sccb_clk k=%0d", k), sccb_clk, ((k % 8) >= 4));
      check($sformatf("data_pulse k=%0d", k), data_pulse, ((k % 8) == 2));
      @(negedge clk);
    end

    t = '{16'h1280, 16'h1101, 16'hFFFF}; load(t);
    run("two writes", 0);

    t = '{16'h3A04, 16'hFFF0, 16'h4000, 16'hFFFF}; load(t);
    run("delay marker", 0);

    t = '{16'h1280, 16'h1101, 16'h2233, 16'hFFFF}; load(t);
    for (int a = 0; a <= MAXR; a++) nack_plan[1][a] = 1;
    run("nack exhausted", 0);

    t = '{16'h1280, 16'h1101, 16'h2233, 16'hFFFF}; load(t);
    nack_plan[1][0] = 1;
    run("nack once", 0);

    t.delete();
    for (int i = 0; i < NE; i++) t.push_back(16'h0100 + 16'(i));
    load(t);
    run("table wrap", 1);

    // Reset while a write is being issued.
    t = '{16'h5511, 16'h6622, 16'hFFFF}; load(t);
    pulse_go();
    n = 0;
    while (!start && n < 100) begin @(negedge clk); n++; end
    check("start_o seen before reset", start, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mid-issue reset start_o", start, 0);
    check("mid-issue reset busy_o", busy, 0);
    @(negedge clk);
    check("mid-issue reset start_o next cycle", start, 0);
    rst_n = 1'b1;
    run("restart after reset", 0);

    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(1, NE));
      t.delete();
      for (int i = 0; i < len; i++) begin
        v = 16'($urandom);
        if (v >= 16'hFFF0) v = v ^ 16'h8000;
        if ($urandom_range(0, 7) == 0) v = 16'hFFF0;
        t.push_back(v);
      end
      load(t);
      for (int i = 0; i < NE; i++)
        for (int a = 0; a <= MAXR; a++) nack_plan[i][a] = ($urandom_range(0, 3) == 0);
      run($sformatf("random %0d", r), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
